// File: rtl/pll_ctrl_pkg.sv
// Shared types and the PLL mode table for pll_ctrl.
// Each mode entry holds divider codes already encoded for the PLL dynamic
// ports. Those ports take (64 - divide_ratio) in 6 bits.
package pll_ctrl_pkg;

    localparam int unsigned MAX_MODES = 16;

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StWaitLock,
        StReady,
        StFail
    } pll_state_e;

    typedef struct packed {
        logic [5:0] idsel;
        logic [5:0] fbdsel;
        logic [5:0] odsel;
    } pll_cfg_t;

    // Convert a divide ratio into the 6-bit dynamic-port encoding.
    function automatic logic [5:0] enc_div(input int unsigned div);
        return 6'(64 - div);
    endfunction

    // 27 MHz -> 371.25 MHz: HDMI 720p60 pixel-serial clock (27 * 55 / 4).
    localparam pll_cfg_t CFG_HDMI_720P =
        '{idsel: enc_div(4), fbdsel: enc_div(55), odsel: enc_div(2)};
    // 27 MHz -> 135 MHz: 480p serial clock (27 * 5 / 1).
    localparam pll_cfg_t CFG_480P =
        '{idsel: enc_div(1), fbdsel: enc_div(5), odsel: enc_div(4)};
    // 27 MHz -> ~200 MHz: 800x600@60 serial clock (27 * 37 / 5).
    localparam pll_cfg_t CFG_SVGA =
        '{idsel: enc_div(5), fbdsel: enc_div(37), odsel: enc_div(4)};
    // 27 MHz -> ~325 MHz: 1024x768@60 serial clock (27 * 12 / 1).
    localparam pll_cfg_t CFG_XGA =
        '{idsel: enc_div(1), fbdsel: enc_div(12), odsel: enc_div(2)};

    // Mode table lookup. Unpopulated slots fall back to the HDMI default.
    function automatic pll_cfg_t mode_cfg(input logic [3:0] mode);
        pll_cfg_t cfg;
        case (mode)
            4'd0:    cfg = CFG_HDMI_720P;
            4'd1:    cfg = CFG_480P;
            4'd2:    cfg = CFG_SVGA;
            4'd3:    cfg = CFG_XGA;
            default: cfg = CFG_HDMI_720P;
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Lock qualifier for pll_ctrl. The raw PLL lock is asynchronous to clkin, so
// it first passes through two flops. A counter then tracks consecutive
// synchronised-high cycles while enabled. stable is asserted combinationally
// during the LOCK_STABLE-th such cycle.
module pll_lock_filter #(
    parameter int unsigned LOCK_STABLE = 256
) (
    input  logic clkin,
    input  logic rst_n,
    input  logic pll_lock,
    input  logic en,
    output logic lock_s,
    output logic stable
);

    localparam int unsigned CW = $clog2(LOCK_STABLE + 1);
    localparam logic [CW-1:0] LAST = CW'(LOCK_STABLE - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Two-flop synchroniser for the asynchronous lock input.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_lock;
            sync2_q <= sync1_q;
        end
    end

    // Count run length. Any low cycle, or being disabled, restarts the count.
    always_comb begin
        cnt_d = '0;
        if (en && sync2_q) begin
            cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + CW'(1);
        end
    end

    // Stability counter register.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign lock_s = sync2_q;
    assign stable = en && sync2_q && (cnt_q == LAST);

endmodule

// File: rtl/pll_ctrl.sv
// PLL bring-up and mode-switch controller.
// The controller resets the PLL with the selected divider codes and waits for
// a stable lock. A lock attempt that times out is retried, and the controller
// gives up (fail) after MAX_RETRY attempts.
// Build option PLL_CTRL_RELOCK_EN: when defined, a lock loss in READY triggers
// an automatic relock of the same mode. Otherwise a lock loss goes to FAIL.
module pll_ctrl #(
    parameter int unsigned NUM_MODES    = 4,
    parameter int unsigned RST_HOLD     = 32,
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned LOCK_TIMEOUT = 27000,
    parameter int unsigned MAX_RETRY    = 3,
    localparam int unsigned MW          = $clog2(NUM_MODES)
) (
    input  logic          clkin,
    input  logic          rst_n,
    input  logic [MW-1:0] mode_sel,
    input  logic          mode_req,
    input  logic          pll_lock,
    output logic          pll_reset,
    output logic [5:0]    idsel,
    output logic [5:0]    fbdsel,
    output logic [5:0]    odsel,
    output logic [MW-1:0] cur_mode,
    output logic          ready,
    output logic          busy,
    output logic          fail
);

    import pll_ctrl_pkg::*;

    localparam int unsigned RCW = $clog2(RST_HOLD + 1);
    localparam int unsigned TCW = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned YCW = $clog2(MAX_RETRY + 1);

    pll_state_e     state_q;
    pll_state_e     state_d;
    logic [MW-1:0]  mode_q;
    logic [MW-1:0]  mode_d;
    logic [RCW-1:0] rst_cnt_q;
    logic [RCW-1:0] rst_cnt_d;
    logic [TCW-1:0] to_cnt_q;
    logic [TCW-1:0] to_cnt_d;
    logic [YCW-1:0] retry_q;
    logic [YCW-1:0] retry_d;
    pll_cfg_t       cfg_q;
    logic           cfg_load;
    logic           wait_en;
    logic           lock_s;
    logic           stable;
    logic           req_ok;
    logic           pll_reset_q;
    logic           ready_q;
    logic           busy_q;
    logic           fail_q;

    assign wait_en = (state_q == StWaitLock);

    pll_lock_filter #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_filter (
        .clkin    (clkin),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .en       (wait_en),
        .lock_s   (lock_s),
        .stable   (stable)
    );

    // A request for a mode outside the table is dropped entirely.
    assign req_ok = mode_req && (32'(mode_sel) < NUM_MODES);

    // Next-state logic. cfg_load marks every entry into RST.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        retry_d   = retry_q;
        rst_cnt_d = '0;
        to_cnt_d  = '0;
        cfg_load  = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d  = StRst;
                mode_d   = '0;
                retry_d  = '0;
                cfg_load = 1'b1;
            end
            StRst: begin
                if (rst_cnt_q == RCW'(RST_HOLD - 1)) begin
                    state_d = StWaitLock;
                end else begin
                    rst_cnt_d = rst_cnt_q + RCW'(1);
                end
            end
            StWaitLock: begin
                // Reaching stability wins over a coincident timeout.
                if (stable) begin
                    state_d = StReady;
                end else if (to_cnt_q == TCW'(LOCK_TIMEOUT - 1)) begin
                    if (retry_q == YCW'(MAX_RETRY - 1)) begin
                        state_d = StFail;
                    end else begin
                        state_d  = StRst;
                        retry_d  = retry_q + YCW'(1);
                        cfg_load = 1'b1;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TCW'(1);
                end
            end
            StReady: begin
                // A valid request takes priority over a coincident lock loss.
                if (req_ok) begin
                    state_d  = StRst;
                    mode_d   = mode_sel;
                    retry_d  = '0;
                    cfg_load = 1'b1;
                end else if (!lock_s) begin
`ifdef PLL_CTRL_RELOCK_EN
                    state_d  = StRst;
                    retry_d  = '0;
                    cfg_load = 1'b1;
`else
                    state_d  = StFail;
`endif
                end
            end
            StFail: begin
                if (req_ok) begin
                    state_d  = StRst;
                    mode_d   = mode_sel;
                    retry_d  = '0;
                    cfg_load = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, counters, divider codes and registered status outputs.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mode_q      <= '0;
            rst_cnt_q   <= '0;
            to_cnt_q    <= '0;
            retry_q     <= '0;
            cfg_q       <= CFG_HDMI_720P;
            pll_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            rst_cnt_q <= rst_cnt_d;
            to_cnt_q  <= to_cnt_d;
            retry_q   <= retry_d;
            if (cfg_load) begin
                cfg_q <= mode_cfg(4'(mode_d));
            end
            // Status outputs are flops decoded from the next state, so they are glitch-free.
            pll_reset_q <= (state_d == StIdle) || (state_d == StRst);
            ready_q     <= (state_d == StReady);
            busy_q      <= (state_d == StRst) || (state_d == StWaitLock);
            fail_q      <= (state_d == StFail);
        end
    end

    assign pll_reset = pll_reset_q;
    assign idsel     = cfg_q.idsel;
    assign fbdsel    = cfg_q.fbdsel;
    assign odsel     = cfg_q.odsel;
    assign cur_mode  = mode_q;
    assign ready     = ready_q;
    assign busy      = busy_q;
    assign fail      = fail_q;

endmodule

// File: tb/tb_pll_ctrl.sv
// Scoreboard bench for pll_ctrl. The stimulus pushes expected output events
// (RST pulses, ready rise, fail rise) and snapshots. Monitors pop and compare.
// Timeout is shortened to keep the run short. NUM_MODES=5 lets mode_sel=5
// exercise the out-of-range path.
module tb_pll_ctrl;

    localparam int unsigned NUM_MODES    = 5;
    localparam int unsigned RST_HOLD     = 32;
    localparam int unsigned LOCK_STABLE  = 256;
    localparam int unsigned LOCK_TIMEOUT = 2000;
    localparam int unsigned MAX_RETRY    = 3;
    localparam int unsigned MW           = $clog2(NUM_MODES);
    localparam int          PERIOD       = RST_HOLD + LOCK_TIMEOUT;

    // Hand-encoded divider codes (64 - ratio) for each mode.
    localparam int EXP_ID [NUM_MODES] = '{60, 63, 59, 63, 60};
    localparam int EXP_FB [NUM_MODES] = '{9, 59, 27, 52, 9};
    localparam int EXP_OD [NUM_MODES] = '{62, 60, 60, 62, 62};

    typedef enum int {EvPulse, EvReady, EvFail} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       cyc;
        int       mode;
    } ev_t;
    typedef struct {
        string name;
        int    pr;
        int    rd;
        int    bz;
        int    fl;
        int    mode;
    } snap_t;

    logic          clkin = 1'b0;
    logic          rst_n = 1'b0;
    logic [MW-1:0] mode_sel = '0;
    logic          mode_req = 1'b0;
    logic          pll_lock = 1'b0;
    logic          pll_reset;
    logic [5:0]    idsel;
    logic [5:0]    fbdsel;
    logic [5:0]    odsel;
    logic [MW-1:0] cur_mode;
    logic          ready;
    logic          busy;
    logic          fail;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    ev_t   evq[$];
    snap_t snapq[$];
    event  snap_ev;

    pll_ctrl #(
        .NUM_MODES    (NUM_MODES),
        .RST_HOLD     (RST_HOLD),
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clkin    (clkin),
        .rst_n    (rst_n),
        .mode_sel (mode_sel),
        .mode_req (mode_req),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .idsel    (idsel),
        .fbdsel   (fbdsel),
        .odsel    (odsel),
        .cur_mode (cur_mode),
        .ready    (ready),
        .busy     (busy),
        .fail     (fail)
    );

    always #5 clkin = ~clkin;
    always @(posedge clkin) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Pop the oldest expected event and compare it with what the DUT just did.
    function automatic void take(input ev_kind_e k, input int c, input int len, input int m,
                                 input int id, input int fb, input int od);
        ev_t e;
        if (evq.size() == 0) begin
            check("unexpected_event_kind", int'(k), -1);
            return;
        end
        e = evq.pop_front();
        check("event_kind", int'(k), int'(e.kind));
        if (e.cyc >= 0) check("event_cycle", c, e.cyc);
        if (k == EvPulse) check("rst_pulse_len", len, RST_HOLD);
        check("event_cur_mode", m, e.mode);
        check("event_idsel", id, EXP_ID[e.mode]);
        check("event_fbdsel", fb, EXP_FB[e.mode]);
        check("event_odsel", od, EXP_OD[e.mode]);
    endfunction

    // Output-event monitor: RST pulse ends, ready rise, fail rise.
    initial begin : monitor
        bit rst_on;
        bit rst_on_q;
        bit ready_q;
        bit fail_q;
        int p_start;
        int p_mode;
        int p_id;
        int p_fb;
        int p_od;
        rst_on_q = 1'b0;
        ready_q  = 1'b0;
        fail_q   = 1'b0;
        p_start  = 0;
        p_mode   = 0;
        p_id     = 0;
        p_fb     = 0;
        p_od     = 0;
        forever begin
            @(posedge clkin);
            #1;
            rst_on = pll_reset && busy;
            if (ready && busy) check("ready_busy_exclusive", 1, 0);
            if (rst_on && !rst_on_q) begin
                p_start = cyc;
                p_mode  = int'(cur_mode);
                p_id    = int'(idsel);
                p_fb    = int'(fbdsel);
                p_od    = int'(odsel);
            end
            if (!rst_on && rst_on_q) take(EvPulse, p_start, cyc - p_start, p_mode, p_id, p_fb, p_od);
            if (ready && !ready_q) take(EvReady, cyc, 0, int'(cur_mode), int'(idsel),
                                        int'(fbdsel), int'(odsel));
            if (fail && !fail_q) take(EvFail, cyc, 0, int'(cur_mode), int'(idsel),
                                      int'(fbdsel), int'(odsel));
            rst_on_q = rst_on;
            ready_q  = ready;
            fail_q   = fail;
        end
    end

    // Snapshot monitor: compares the full output vector on request.
    always begin
        @(snap_ev);
        while (snapq.size() > 0) begin
            snap_t s;
            s = snapq.pop_front();
            check({s.name, "_pll_reset"}, int'(pll_reset), s.pr);
            check({s.name, "_ready"}, int'(ready), s.rd);
            check({s.name, "_busy"}, int'(busy), s.bz);
            check({s.name, "_fail"}, int'(fail), s.fl);
            check({s.name, "_cur_mode"}, int'(cur_mode), s.mode);
            check({s.name, "_idsel"}, int'(idsel), EXP_ID[s.mode]);
            check({s.name, "_fbdsel"}, int'(fbdsel), EXP_FB[s.mode]);
            check({s.name, "_odsel"}, int'(odsel), EXP_OD[s.mode]);
        end
    end

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push_ev(input ev_kind_e k, input int c, input int m);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.mode = m;
        evq.push_back(e);
    endtask

    task automatic snap(input string name, input int pr, input int rd, input int bz,
                        input int fl, input int m);
        snap_t s;
        s.name = name;
        s.pr   = pr;
        s.rd   = rd;
        s.bz   = bz;
        s.fl   = fl;
        s.mode = m;
        snapq.push_back(s);
        ->snap_ev;
        #0;
    endtask

    // One-cycle request strobe; returns one cycle after it is issued.
    task automatic request(input int m);
        mode_sel = MW'(m);
        mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
    endtask

    // Bounded wait for ready (which=0) or fail (which=1).
    task automatic wait_for(input string name, input int which, input int limit);
        int n;
        n = 0;
        while (((which == 0) ? !ready : !fail) && n < limit) begin
            tick();
            n++;
        end
        if ((which == 0) ? !ready : !fail) check({name, "_wait_expired"}, 0, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no completion, want completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int r;
        int t;
        int s;

        // Reset values and first bring-up of mode 0.
        repeat (3) tick();
        snap("in_reset", 1, 0, 0, 0, 0);
        r = cyc;
        rst_n = 1'b1;
        push_ev(EvPulse, r + 1, 0);
        go_to(r + 40);
        pll_lock = 1'b1;
        push_ev(EvReady, cyc + 2 + LOCK_STABLE, 0);
        wait_for("bringup", 0, 400);

        // Switch to mode 2; a request during WAIT_LOCK is ignored.
        tick();
        t = cyc;
        push_ev(EvPulse, t + 1, 2);
        push_ev(EvReady, t + 1 + RST_HOLD + LOCK_STABLE, 2);
        request(2);
        snap("rst_entry", 1, 0, 1, 0, 2);
        go_to(t + 100);
        request(3);
        snap("req_in_wait", 0, 0, 1, 0, 2);
        wait_for("mode2", 0, 400);

        // Out-of-range mode is ignored in READY.
        tick();
        request(5);
        snap("bad_mode", 0, 1, 0, 0, 2);
        repeat (5) tick();
        snap("bad_mode_later", 0, 1, 0, 0, 2);

        // Lock falls in the same cycle as a request: the request wins. Lock
        // then stays low, so three attempts run and the controller fails.
        tick();
        t = cyc;
        pll_lock = 1'b0;
        tick();
        tick();
        s = t + 3;
        push_ev(EvPulse, s, 1);
        push_ev(EvPulse, s + PERIOD, 1);
        push_ev(EvPulse, s + 2 * PERIOD, 1);
        push_ev(EvFail, s + 3 * PERIOD, 1);
        request(1);
        wait_for("lock_low", 1, 3 * PERIOD + 100);
        snap("retries_exhausted", 0, 0, 0, 1, 1);

        // A request from FAIL clears fail and brings up mode 3.
        tick();
        t = cyc;
        pll_lock = 1'b1;
        push_ev(EvPulse, t + 1, 3);
        push_ev(EvReady, t + 1 + RST_HOLD + LOCK_STABLE, 3);
        request(3);
        snap("fail_cleared", 1, 0, 1, 0, 3);
        wait_for("from_fail", 0, 400);

        // Chattering lock (255 high, 1 low) never qualifies; the attempt times out.
        tick();
        t = cyc;
        push_ev(EvPulse, t + 1, 0);
        push_ev(EvPulse, t + 1 + PERIOD, 0);
        push_ev(EvReady, t + 1 + PERIOD + RST_HOLD + LOCK_STABLE, 0);
        mode_sel = '0;
        mode_req = 1'b1;
        for (int k = 0; k < PERIOD + 8; k++) begin
            pll_lock = ((k % 256) != 255);
            tick();
            mode_req = 1'b0;
        end
        pll_lock = 1'b1;
        wait_for("chatter_recover", 0, 600);

        // Lock drop in READY.
        tick();
        t = cyc;
        pll_lock = 1'b0;
`ifdef PLL_CTRL_RELOCK_EN
        push_ev(EvPulse, t + 3, 0);
        push_ev(EvReady, t + 3 + RST_HOLD + LOCK_STABLE, 0);
        go_to(t + 3);
        snap("relock_rst", 1, 0, 1, 0, 0);
        go_to(t + 10);
        pll_lock = 1'b1;
        wait_for("relock", 0, 400);
`else
        push_ev(EvFail, t + 3, 0);
        go_to(t + 3);
        snap("drop_fail", 0, 0, 0, 1, 0);
`endif

        // Reset mid-sequence abandons the attempt.
        tick();
        t = cyc;
        push_ev(EvPulse, t + 1, 2);
        request(2);
        go_to(t + 50);
        #2;
        rst_n = 1'b0;
        #1;
        snap("mid_reset", 1, 0, 0, 0, 0);
        repeat (5) tick();
        snap("held_reset", 1, 0, 0, 0, 0);

        check("events_outstanding", evq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
